// File: rtl/jclk_pkg.sv
// ----------------------------------------------------------------------------
// jclk_pkg
// Shared definitions for the clock generator register writer:
//   - bus word offsets of CLK1/CLK2/CLK3
//   - shadow register reset values (match the clock generator reset state)
//   - writer FSM state encoding
//   - write FIFO entry layout
//   - helpers: strobe one-hot select and readback bit mask per offset
// ----------------------------------------------------------------------------
package jclk_pkg;

    localparam logic [1:0] JCLK_CLK1_OFS = 2'd0;
    localparam logic [1:0] JCLK_CLK2_OFS = 2'd1;
    localparam logic [1:0] JCLK_CLK3_OFS = 2'd2;
    localparam logic [1:0] JCLK_NONE_OFS = 2'd3;

    localparam logic [15:0] JCLK_CLK1_RST = 16'h0001;
    localparam logic [15:0] JCLK_CLK2_RST = 16'h0000;
    localparam logic [15:0] JCLK_CLK3_RST = 16'h003F;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } jclk_state_e;

    typedef struct packed {
        logic [1:0]  addr;
        logic [15:0] data;
    } jclk_wr_entry_t;

    // One-hot {clk3w, clk2w, clk1w} for a register offset.
    function automatic logic [2:0] jclk_strobe_sel(input logic [1:0] addr);
        logic [2:0] sel;
        sel = '0;
        unique case (addr)
            JCLK_CLK1_OFS: sel = 3'b001;
            JCLK_CLK2_OFS: sel = 3'b010;
            JCLK_CLK3_OFS: sel = 3'b100;
            default:       sel = '0;
        endcase
        return sel;
    endfunction

    // Bits physically implemented in each clock generator register.
    function automatic logic [15:0] jclk_reg_mask(input logic [1:0] addr);
        logic [15:0] mask;
        mask = '0;
        unique case (addr)
            JCLK_CLK1_OFS: mask = 16'h03FF;
            JCLK_CLK2_OFS: mask = 16'h03FF;
            JCLK_CLK3_OFS: mask = 16'h803F;
            default:       mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/jclk_wr_fifo.sv
// ----------------------------------------------------------------------------
// jclk_wr_fifo
// Two-entry synchronous FIFO holding pending register writes.
// full_o/empty_o are registered; push while full and pop while empty are
// ignored. Push and pop together keep the count and preserve order.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   push_i, push_data_i   enqueue request and entry
//   pop_i            dequeue request (head shown on pop_data_o)
//   pop_data_o       current head entry
//   full_o, empty_o  occupancy flags
// ----------------------------------------------------------------------------
module jclk_wr_fifo
    import jclk_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           push_i,
    input  jclk_wr_entry_t push_data_i,
    input  logic           pop_i,
    output jclk_wr_entry_t pop_data_o,
    output logic           full_o,
    output logic           empty_o
);

    jclk_wr_entry_t mem_q [2];
    logic           wr_ptr_q;
    logic           rd_ptr_q;
    logic [1:0]     count_q;
    logic [1:0]     count_d;
    logic           full_q;
    logic           empty_q;
    logic           do_push;
    logic           do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
            full_q  <= (count_d == 2'd2);
            empty_q <= (count_d == 2'd0);
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/jclk_regif.sv
// ----------------------------------------------------------------------------
// jclk_regif
// Host-side writer for the clock generator registers CLK1/CLK2/CLK3.
// Bus writes are queued (2 deep) and each is played out as
// SETUP (din valid) -> STROBE (STROBE_CYCLES, one clkNw high) -> HOLD,
// so din is stable around the whole level-sensitive latch window.
// Optional shadow readback: define JCLK_REGIF_READBACK_EN.
// Parameters:
//   STROBE_CYCLES   cycles each clkNw is high (1..15)
// Ports:
//   sys_clk, reset            clock, asynchronous active-high reset
//   bus_wr_valid/ready        write handshake (ready = FIFO not full)
//   bus_addr, bus_wdata       word offset (0..2 mapped, 3 dropped), data
//   bus_rd, bus_rdata, bus_rd_valid   one-cycle read, data next cycle
//   wr_drop                   pulse after an accepted write to offset 3
//   din, din_15               data to the clock generator
//   clk1w, clk2w, clk3w       level load strobes
//   busy                      FIFO non-empty or sequence in progress
// ----------------------------------------------------------------------------
module jclk_regif
    import jclk_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        bus_wr_valid,
    output logic        bus_wr_ready,
    input  logic [1:0]  bus_addr,
    input  logic [15:0] bus_wdata,
    input  logic        bus_rd,
    output logic [15:0] bus_rdata,
    output logic        bus_rd_valid,
    output logic        wr_drop,
    output logic [9:0]  din,
    output logic        din_15,
    output logic        clk1w,
    output logic        clk2w,
    output logic        clk3w,
    output logic        busy
);

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    jclk_state_e    state_q;
    logic [1:0]     addr_q;
    logic [3:0]     cnt_q;
    logic [9:0]     din_q;
    logic           din_15_q;
    logic [2:0]     strobe_q;
    logic           wr_drop_q;
    logic           rd_valid_q;

    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    jclk_wr_entry_t fifo_head;
    jclk_wr_entry_t fifo_in;
    logic           wr_accept;
    logic           wr_mapped;
    logic           head_unused;

    assign wr_accept = bus_wr_valid & ~fifo_full;
    assign wr_mapped = (bus_addr != JCLK_NONE_OFS);
    assign fifo_in   = '{addr: bus_addr, data: bus_wdata};

    // The FSM takes a new entry from IDLE or straight out of HOLD.
    assign fifo_pop  = ((state_q == IDLE) || (state_q == HOLD)) & ~fifo_empty;

    // Bits 14:10 have no destination in the clock generator.
    assign head_unused = ^fifo_head.data[14:10];

    jclk_wr_fifo u_fifo (
        .clk_i       (sys_clk),
        .rst_i       (reset),
        .push_i      (wr_accept & wr_mapped),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            din_q    <= '0;
            din_15_q <= 1'b0;
            strobe_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, HOLD: begin
                    if (!fifo_empty) begin
                        state_q  <= SETUP;
                        addr_q   <= fifo_head.addr;
                        din_q    <= fifo_head.data[9:0];
                        din_15_q <= fifo_head.data[15];
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                SETUP: begin
                    state_q  <= STROBE;
                    cnt_q    <= STROBE_LOAD;
                    strobe_q <= jclk_strobe_sel(addr_q);
                end
                STROBE: begin
                    if (cnt_q == '0) begin
                        state_q  <= HOLD;
                        strobe_q <= '0;
                    end else begin
                        cnt_q    <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            wr_drop_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_drop_q  <= wr_accept & ~wr_mapped;
            rd_valid_q <= bus_rd;
        end
    end

`ifdef JCLK_REGIF_READBACK_EN
    logic [15:0] shadow1_q;
    logic [15:0] shadow2_q;
    logic [15:0] shadow3_q;
    logic [15:0] shadow_wr;
    logic [15:0] rd_mux;
    logic [15:0] rdata_q;

    // SETUP->STROBE is the cycle STROBE is entered; din already holds the data.
    assign shadow_wr = {din_15_q, 5'b0, din_q} & jclk_reg_mask(addr_q);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            shadow1_q <= JCLK_CLK1_RST;
            shadow2_q <= JCLK_CLK2_RST;
            shadow3_q <= JCLK_CLK3_RST;
        end else if (state_q == SETUP) begin
            unique case (addr_q)
                JCLK_CLK1_OFS: shadow1_q <= shadow_wr;
                JCLK_CLK2_OFS: shadow2_q <= shadow_wr;
                JCLK_CLK3_OFS: shadow3_q <= shadow_wr;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (bus_addr)
            JCLK_CLK1_OFS: rd_mux = shadow1_q;
            JCLK_CLK2_OFS: rd_mux = shadow2_q;
            JCLK_CLK3_OFS: rd_mux = shadow3_q;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (bus_rd) begin
            rdata_q <= rd_mux;
        end
    end

    assign bus_rdata = rdata_q;
`else
    assign bus_rdata = '0;
`endif

    assign bus_wr_ready = ~fifo_full;
    assign bus_rd_valid = rd_valid_q;
    assign wr_drop      = wr_drop_q;
    assign din          = din_q;
    assign din_15       = din_15_q;
    assign clk1w        = strobe_q[0];
    assign clk2w        = strobe_q[1];
    assign clk3w        = strobe_q[2];
    assign busy         = ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_jclk_regif.sv
// ----------------------------------------------------------------------------
// tb_jclk_regif
// Scoreboard bench for jclk_regif: the driver pushes expected strobes,
// read data and drop pulses into queues; a negedge monitor pops and
// compares whenever the DUT presents one of those outputs.
// Expected readback follows JCLK_REGIF_READBACK_EN when defined.
// ----------------------------------------------------------------------------
module tb_jclk_regif;

    localparam int unsigned SC = 2;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        bus_wr_valid = 1'b0;
    logic        bus_wr_ready;
    logic [1:0]  bus_addr = '0;
    logic [15:0] bus_wdata = '0;
    logic        bus_rd = 1'b0;
    logic [15:0] bus_rdata;
    logic        bus_rd_valid;
    logic        wr_drop;
    logic [9:0]  din;
    logic        din_15;
    logic        clk1w, clk2w, clk3w;
    logic        busy;

    jclk_regif #(.STROBE_CYCLES(SC)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .bus_wr_valid (bus_wr_valid),
        .bus_wr_ready (bus_wr_ready),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rd       (bus_rd),
        .bus_rdata    (bus_rdata),
        .bus_rd_valid (bus_rd_valid),
        .wr_drop      (wr_drop),
        .din          (din),
        .din_15       (din_15),
        .clk1w        (clk1w),
        .clk2w        (clk2w),
        .clk3w        (clk3w),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [2:0] sel; logic [10:0] data; } sexp_t;
    typedef struct { logic [15:0] data; int unsigned when; } rexp_t;

    sexp_t       sq[$];
    rexp_t       rq[$];
    int unsigned dq[$];
    int unsigned rises[$];
    int unsigned last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rb(input logic [15:0] v);
`ifdef JCLK_REGIF_READBACK_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    // ------------------------------------------------------------ monitor
    logic        in_pulse = 1'b0;
    int unsigned width;
    logic [2:0]  cur_sel;
    logic [10:0] held;
    logic        moved;

    always @(negedge sys_clk) begin
        logic [2:0] strb;
        sexp_t se;
        rexp_t re;
        int unsigned de;
        strb = {clk3w, clk2w, clk1w};
        if (reset) begin
            in_pulse = 1'b0;
        end else begin
            if (!in_pulse && strb != 3'b000) begin
                rises.push_back(cyc);
                if (sq.size() == 0) begin
                    chk("unexpected_strobe", {29'd0, strb}, 32'd0);
                end else begin
                    se = sq.pop_front();
                    chk("strobe_sel", {29'd0, strb}, {29'd0, se.sel});
                    chk("strobe_din", {21'd0, din_15, din}, {21'd0, se.data});
                end
                in_pulse = 1'b1;
                width    = 1;
                cur_sel  = strb;
                held     = {din_15, din};
                moved    = 1'b0;
            end else if (in_pulse && strb != 3'b000) begin
                width++;
                if (strb != cur_sel || {din_15, din} != held) moved = 1'b1;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                chk("strobe_width", width, SC);
                chk("strobe_stable", {31'd0, moved}, 32'd0);
                chk("hold_din", {21'd0, din_15, din}, {21'd0, held});
            end

            if (bus_rd_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rd_valid", 32'd1, 32'd0);
                end else begin
                    re = rq.pop_front();
                    chk("rd_data", {16'd0, bus_rdata}, {16'd0, re.data});
                    chk("rd_latency", cyc, re.when);
                end
            end

            if (wr_drop) begin
                if (dq.size() == 0) begin
                    chk("unexpected_wr_drop", 32'd1, 32'd0);
                end else begin
                    de = dq.pop_front();
                    chk("wr_drop_cycle", cyc, de);
                end
            end
        end
    end

    // ------------------------------------------------------------ driver
    // All driver tasks start and end on a negedge.
    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        int unsigned t;
        t = 0;
        bus_wr_valid = 1'b1;
        bus_addr     = a;
        bus_wdata    = d;
        while (!bus_wr_ready) begin
            if (t == 50) begin
                chk("wr_ready_timeout", 32'd0, 32'd1);
                bus_wr_valid = 1'b0;
                return;
            end
            @(negedge sys_clk);
            t++;
        end
        last_acc = cyc;
        if (a == 2'd3) begin
            dq.push_back(cyc + 1);
        end else begin
            sq.push_back('{sel: (a == 2'd0) ? 3'b001 : (a == 2'd1) ? 3'b010 : 3'b100,
                           data: {d[15], d[9:0]}});
        end
        @(negedge sys_clk);
        bus_wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] exp);
        bus_rd   = 1'b1;
        bus_addr = a;
        rq.push_back('{data: exp, when: cyc + 1});
        @(negedge sys_clk);
        bus_rd   = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned t;
        t = 0;
        while (busy || in_pulse) begin
            if (t == 100) begin
                chk("idle_timeout", {31'd0, busy}, 32'd0);
                return;
            end
            @(negedge sys_clk);
            t++;
        end
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic wait_strobe(input logic [2:0] sel, output int unsigned at);
        int unsigned t;
        t  = 0;
        at = 0;
        while (({clk3w, clk2w, clk1w} & sel) == 3'b000) begin
            if (t == 20) begin
                chk("strobe_timeout", 32'd0, {29'd0, sel});
                return;
            end
            @(negedge sys_clk);
            t++;
        end
        at = cyc;
    endtask

    initial begin
        int unsigned at;
        int unsigned base;

        // Reset state
        repeat (2) @(negedge sys_clk);
        chk("rst_din", {22'd0, din}, 32'd0);
        chk("rst_din_15", {31'd0, din_15}, 32'd0);
        chk("rst_strobes", {29'd0, clk3w, clk2w, clk1w}, 32'd0);
        chk("rst_wr_ready", {31'd0, bus_wr_ready}, 32'd1);
        chk("rst_rd_valid", {31'd0, bus_rd_valid}, 32'd0);
        chk("rst_rdata", {16'd0, bus_rdata}, 32'd0);
        chk("rst_wr_drop", {31'd0, wr_drop}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge sys_clk);

        // Reset readback values
        rd(2'd0, rb(16'h0001));
        rd(2'd1, rb(16'h0000));
        rd(2'd2, rb(16'h003F));
        rd(2'd3, 16'h0000);
        @(negedge sys_clk);

        // Single CLK2 write: latency of 3 cycles from the accept cycle
        wr(2'd1, 16'h0123);
        wait_strobe(3'b010, at);
        chk("wr_latency", at - last_acc, 32'd3);
        wait_idle();
        rd(2'd1, rb(16'h0123));

        // CLK3 write with vclken
        wr(2'd2, 16'h8015);
        wait_idle();
        rd(2'd2, rb(16'h8015));

        // Back-to-back writes plus one that must stall on full
        rises.delete();
        wr(2'd0, 16'h03A5);
        wr(2'd1, 16'h0FFF);
        wr(2'd2, 16'h7FC0);
        chk("ready_low_when_full", {31'd0, bus_wr_ready}, 32'd0);
        wr(2'd0, 16'h0001);
        wait_idle();
        chk("b2b_strobe_count", rises.size(), 32'd4);
        if (rises.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("b2b_no_gap", rises[i] - rises[i-1], SC + 2);
        end
        rd(2'd0, rb(16'h0001));
        rd(2'd1, rb(16'h03FF));
        rd(2'd2, rb(16'h0000));

        // Unmapped write is dropped
        wr(2'd3, 16'hFFFF);
        chk("unmapped_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge sys_clk);
        chk("unmapped_busy_later", {31'd0, busy}, 32'd0);

        // Read while the write is still queued sees the old shadow
        wr(2'd1, 16'h0222);
        rd(2'd1, rb(16'h03FF));
        wait_idle();
        rd(2'd1, rb(16'h0222));

        // Reset during STROBE of a CLK1 write with another write queued
        wr(2'd0, 16'h0055);
        wr(2'd1, 16'h0077);
        wait_strobe(3'b001, at);
        base = at;
        #2 reset = 1'b1;
        #1 chk("clk1w_async_drop", {31'd0, clk1w}, 32'd0);
        chk("rst_mid_din", {21'd0, din_15, din}, 32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b0;
        sq.delete();
        @(negedge sys_clk);
        chk("busy_after_reset", {31'd0, busy}, 32'd0);
        rd(2'd0, rb(16'h0001));
        rises.delete();
        repeat (12) @(negedge sys_clk);
        chk("no_strobe_after_reset", rises.size(), 32'd0);
        chk("reset_seen_strobe", {31'd0, base != 0}, 32'd1);

        // Nothing left outstanding
        chk("strobe_queue_empty", sq.size(), 32'd0);
        chk("read_queue_empty", rq.size(), 32'd0);
        chk("drop_queue_empty", dq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
